// File: rtl/round_score_accumulator.sv
// round_score_accumulator: per-round closeness scoring with saturating total and best diff; optional HISTORY_EN diff history
module round_score_accumulator #(
  parameter int NUM_ROUNDS  = 5,
  parameter int MAX_POINTS  = 100,
  parameter int EXACT_BONUS = 20
)(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       diff_valid,
  input  logic [6:0] diff,
  output logic       diff_ready,
  output logic       busy,
  output logic [3:0] round_idx,
  output logic [9:0] total_score,
  output logic [6:0] best_diff,
  output logic       done,
  input  logic [1:0] hist_sel,
  output logic [6:0] hist_diff
);
  typedef enum logic [1:0] {IDLE, COLLECT, SCORE, DONE} state_t;
  state_t state;
  logic [6:0] d;
  logic [7:0] pts;
  logic [10:0] sum;
  logic [9:0] sat;
  logic [3:0] next_idx;
  // closeness points for the latched diff and the saturated running total
  always_comb begin
    pts = ({1'b0, d} >= 8'(MAX_POINTS) ? 8'd0 : 8'(MAX_POINTS) - {1'b0, d}) + (d == 7'd0 ? 8'(EXACT_BONUS) : 8'd0);
    sum = {1'b0, total_score} + {3'b0, pts};
    sat = sum[10] ? 10'h3ff : sum[9:0];
    next_idx = round_idx + 4'd1;
  end
  // game FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      d           <= '0;
      diff_ready  <= 1'b0;
      busy        <= 1'b0;
      round_idx   <= '0;
      total_score <= '0;
      best_diff   <= 7'h7f;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          total_score <= '0;
          round_idx   <= '0;
          best_diff   <= 7'h7f;
          busy        <= 1'b1;
          diff_ready  <= 1'b1;
          state       <= COLLECT;
        end
        COLLECT: if (diff_valid && diff_ready) begin
          d          <= diff;
          diff_ready <= 1'b0;
          state      <= SCORE;
        end
        SCORE: begin
          total_score <= sat;
          best_diff   <= d < best_diff ? d : best_diff;
          round_idx   <= next_idx;
          if (next_idx == 4'(NUM_ROUNDS)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            diff_ready <= 1'b1;
            state      <= COLLECT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef HISTORY_EN
  logic [6:0] hist [4];
  // shift in each scored diff, newest at entry 0; a new game starts empty
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) hist <= '{default: '0};
    else if (state == IDLE && start) hist <= '{default: '0};
    else if (state == SCORE) hist <= '{d, hist[0], hist[1], hist[2]};
  assign hist_diff = hist[hist_sel];
`else
  logic unused_sel;
  assign unused_sel = ^hist_sel;
  assign hist_diff = 7'd0;
`endif
endmodule

// File: tb/tb_round_score_accumulator.sv
// tb_round_score_accumulator: directed checks of scoring, handshake, reset, saturation and history
module tb_round_score_accumulator;
  logic clk = 0, reset_n = 0, start = 0, diff_valid = 0;
  logic [6:0] diff = 0;
  logic [1:0] hist_sel = 0;
  logic diff_ready, busy, done, s_ready, s_busy, s_done;
  logic [3:0] round_idx, s_round;
  logic [9:0] total_score, s_total;
  logic [6:0] best_diff, hist_diff, s_best, s_hist;
  int checks = 0, errors = 0, done_cnt = 0, acc_cnt = 0;
  int hexp [4];
  round_score_accumulator dut (
    .clk(clk), .reset_n(reset_n), .start(start), .diff_valid(diff_valid), .diff(diff),
    .diff_ready(diff_ready), .busy(busy), .round_idx(round_idx), .total_score(total_score),
    .best_diff(best_diff), .done(done), .hist_sel(hist_sel), .hist_diff(hist_diff)
  );
  round_score_accumulator #(.NUM_ROUNDS(10)) sat_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .diff_valid(diff_valid), .diff(diff),
    .diff_ready(s_ready), .busy(s_busy), .round_idx(s_round), .total_score(s_total),
    .best_diff(s_best), .done(s_done), .hist_sel(hist_sel), .hist_diff(s_hist)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;
  always @(posedge clk) if (diff_valid && diff_ready) acc_cnt++;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_idle_reset(input string tag);
    chk({tag, "_ready"}, diff_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_round"}, round_idx, 0);
    chk({tag, "_total"}, total_score, 0);
    chk({tag, "_best"}, best_diff, 127);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_hist"}, hist_diff, 0);
    chk({tag, "_s_total"}, s_total, 0);
  endtask
  task automatic do_reset();
    reset_n = 0; start = 0; diff_valid = 0; diff = 0; hist_sel = 0;
    repeat (2) @(negedge clk);
    check_idle_reset("rst");
    reset_n = 1;
    repeat (3) @(negedge clk);
    check_idle_reset("post_rst");
  endtask
  task automatic start_game();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic play(input logic [6:0] v, input bit on_sat);
    diff_valid = 1; diff = v;
    for (int i = 0; i < 20; i++) begin
      if (on_sat ? s_ready : diff_ready) begin
        @(negedge clk);
        diff_valid = 0;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    diff_valid = 0;
    chk("accept_timeout", 0, 1);
  endtask
  initial begin
    logic [6:0] nom [5];
    int npts [5];
    int run;
    nom = '{7'd0, 7'd10, 7'd50, 7'd100, 7'd127};
    npts = '{120, 90, 50, 0, 0};
`ifdef HISTORY_EN
    hexp = '{127, 100, 50, 10};
`else
    hexp = '{0, 0, 0, 0};
`endif
    // nominal game
    do_reset();
    done_cnt = 0;
    start_game();
    chk("nom_busy", busy, 1);
    chk("nom_ready", diff_ready, 1);
    run = 0;
    for (int i = 0; i < 5; i++) begin
      play(nom[i], 0);
      run += npts[i];
      chk($sformatf("nom_total%0d", i), total_score, run);
      chk($sformatf("nom_round%0d", i), round_idx, i + 1);
    end
    chk("nom_done", done, 1);
    chk("nom_best", best_diff, 0);
    chk("nom_busy_done", busy, 1);
    @(negedge clk);
    chk("nom_busy_after", busy, 0);
    chk("nom_done_after", done, 0);
    repeat (3) @(negedge clk);
    chk("nom_done_cnt", done_cnt, 1);
    chk("nom_hold_total", total_score, 260);
    for (int i = 0; i < 4; i++) begin
      hist_sel = 2'(i);
      #1 chk($sformatf("hist%0d", i), hist_diff, hexp[i]);
    end
    start_game();
    for (int i = 0; i < 4; i++) begin
      hist_sel = 2'(i);
      #1 chk($sformatf("hist_clr%0d", i), hist_diff, 0);
    end
    chk("restart_total", total_score, 0);
    chk("restart_best", best_diff, 127);
    // continuous valid, then gap
    do_reset();
    start_game();
    acc_cnt = 0;
    diff_valid = 1; diff = 30;
    repeat (6) @(negedge clk);
    diff_valid = 0;
    chk("hs_acc", acc_cnt, 3);
    chk("hs_total", total_score, 210);
    chk("hs_round", round_idx, 3);
    repeat (5) @(negedge clk);
    chk("gap_round", round_idx, 3);
    chk("gap_total", total_score, 210);
    chk("gap_ready", diff_ready, 1);
    chk("gap_acc", acc_cnt, 3);
    play(30, 0);
    chk("hs_total4", total_score, 280);
    play(30, 0);
    chk("hs_total5", total_score, 350);
    chk("hs_done", done, 1);
    chk("hs_best", best_diff, 30);
    // ignored start and mid-game reset
    do_reset();
    start_game();
    play(5, 0);
    play(5, 0);
    done_cnt = 0;
    start_game();
    @(negedge clk);
    chk("ign_round", round_idx, 2);
    chk("ign_total", total_score, 190);
    chk("ign_busy", busy, 1);
    play(5, 0);
    chk("ign_total3", total_score, 285);
    chk("ign_best", best_diff, 5);
    reset_n = 0;
    #1 check_idle_reset("mid_rst");
    @(negedge clk);
    reset_n = 1;
    repeat (4) @(negedge clk);
    chk("mid_done_cnt", done_cnt, 0);
    chk("mid_busy", busy, 0);
    // saturation with a 10-round game
    do_reset();
    start_game();
    for (int i = 1; i <= 10; i++) begin
      play(0, 1);
      chk($sformatf("sat_total%0d", i), s_total, i <= 8 ? 120 * i : 1023);
    end
    chk("sat_round", s_round, 10);
    chk("sat_best", s_best, 0);
    chk("sat_done", s_done, 1);
    @(negedge clk);
    chk("sat_busy", s_busy, 0);
    chk("sat_hold", s_total, 1023);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
